// File: rtl/digit_addr_gen_if.sv
// Pixel-strobe input and registered video-timing / digit-window outputs of digit_addr_gen.
interface digit_addr_gen_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        in_win;
    logic [12:0] addr;
    logic        win_vld;
    logic        frame_start;

    modport master (
        output pix_en,
        input  hsync, vsync, de, pix_x, pix_y, in_win, addr, win_vld, frame_start
    );

    modport slave (
        input  pix_en,
        output hsync, vsync, de, pix_x, pix_y, in_win, addr, win_vld, frame_start
    );
endinterface

// File: rtl/digit_addr_gen.sv
// 640x480 VGA timing generator that also issues sequential ROM addresses for a
// 64x128 digit window; all outputs describe the same pixel, one strobe behind the counters.
module digit_addr_gen #(
    parameter int WIN_X0 = 288,
    parameter int WIN_Y0 = 176
) (
    input  logic             clk,
    input  logic             rst_n,
    digit_addr_gen_if.slave  bus
);
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] HS_FIRST = 10'd656;
    localparam logic [9:0] HS_LAST  = 10'd751;
    localparam logic [9:0] VS_FIRST = 10'd490;
    localparam logic [9:0] VS_LAST  = 10'd491;
    localparam logic [9:0] WX0      = 10'(WIN_X0);
    localparam logic [9:0] WY0      = 10'(WIN_Y0);

    logic [9:0]  h_cnt_reg;
    logic [9:0]  v_cnt_reg;
    logic        hsync_reg;
    logic        vsync_reg;
    logic        de_reg;
    logic [9:0]  pix_x_reg;
    logic [9:0]  pix_y_reg;
    logic        in_win_reg;
    logic [12:0] addr_reg;
    logic        win_vld_reg;
    logic        frame_start_reg;

    logic [9:0]  h_off;
    logic [9:0]  v_off;
    logic        win_cur;
    logic        frame_origin;

    // Modulo-1024 offsets: counters below the window origin wrap far above the window size.
    assign h_off        = h_cnt_reg - WX0;
    assign v_off        = v_cnt_reg - WY0;
    assign win_cur      = (h_off < 10'd64) && (v_off < 10'd128);
    assign frame_origin = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            de_reg          <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            in_win_reg      <= 1'b0;
            addr_reg        <= '0;
            win_vld_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            win_vld_reg     <= in_win_reg;
            frame_start_reg <= 1'b0;
            if (bus.pix_en) begin
                if (h_cnt_reg == H_LAST) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 10'd1;
                end
                hsync_reg       <= !((h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST));
                vsync_reg       <= !((v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST));
                de_reg          <= (h_cnt_reg < H_ACTIVE) && (v_cnt_reg < V_ACTIVE);
                pix_x_reg       <= h_cnt_reg;
                pix_y_reg       <= v_cnt_reg;
                in_win_reg      <= win_cur;
                frame_start_reg <= frame_origin;
                // Advance past the window pixel currently on the outputs; wraps to 0 after the last one.
                if (frame_origin)
                    addr_reg <= '0;
                else if (in_win_reg)
                    addr_reg <= addr_reg + 13'd1;
            end
        end
    end

    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.de          = de_reg;
    assign bus.pix_x       = pix_x_reg;
    assign bus.pix_y       = pix_y_reg;
    assign bus.in_win      = in_win_reg;
    assign bus.addr        = addr_reg;
    assign bus.win_vld     = win_vld_reg;
    assign bus.frame_start = frame_start_reg;
endmodule
